// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler doing optional victim write-back, line burst refill and tag refresh; optional perf counters under CACHE_REFILL_PERF_EN
module cache_refill_ctrl #(
  parameter int LINE_WORDS = 16,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss,
  input  logic                    write_back,
  input  logic [31:0]             axi_raddr,
  input  logic [31:0]             axi_waddr,
  input  logic                    lru,
  input  logic [32*LINE_WORDS-1:0] victim_line,
  output logic                    rd_req,
  output logic [31:0]             rd_addr,
  input  logic                    rd_addr_ok,
  input  logic                    rd_data_ok,
  input  logic [31:0]             rd_data,
  input  logic                    rd_last,
  output logic                    wr_req,
  output logic [31:0]             wr_addr,
  input  logic                    wr_addr_ok,
  output logic                    wr_wvalid,
  output logic [31:0]             wr_wdata,
  output logic                    wr_wlast,
  input  logic                    wr_data_ok,
  input  logic                    wr_done,
  output logic                    refill_we,
  output logic                    refill_way,
  output logic [CNT_W-1:0]        refill_idx,
  output logic [31:0]             refill_wdata,
  output logic                    refresh,
  output logic                    busy,
  output logic [31:0]             perf_miss_cnt,
  output logic [31:0]             perf_wb_cnt
);
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, WB_RESP, RD_REQ, RD_DATA, REFRESH} state_t;
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [31:0] raddr_q, waddr_q;
  logic lru_q;
  logic [32*LINE_WORDS-1:0] line_q;
  logic start;
  assign start = state == IDLE && miss;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      lru_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      state <= next;
      if (start) begin
        raddr_q <= axi_raddr;
        waddr_q <= axi_waddr;
        lru_q   <= lru;
        line_q  <= victim_line;
      end
      if ((state == WB_REQ && wr_addr_ok) || (state == RD_REQ && rd_addr_ok))
        cnt <= '0;
      else if ((state == WB_DATA && wr_data_ok) || (state == RD_DATA && rd_data_ok))
        cnt <= cnt + 1'b1;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = miss ? (write_back ? WB_REQ : RD_REQ) : IDLE;
      WB_REQ:  next = wr_addr_ok ? WB_DATA : WB_REQ;
      WB_DATA: next = (wr_data_ok && wr_wlast) ? WB_RESP : WB_DATA;
      WB_RESP: next = wr_done ? RD_REQ : WB_RESP;
      RD_REQ:  next = rd_addr_ok ? RD_DATA : RD_REQ;
      RD_DATA: next = (rd_data_ok && rd_last) ? REFRESH : RD_DATA;
      REFRESH: next = IDLE;
      default: next = IDLE;
    endcase
  end
  assign busy         = state != IDLE;
  assign rd_req       = state == RD_REQ;
  assign rd_addr      = rd_req ? raddr_q : '0;
  assign wr_req       = state == WB_REQ;
  assign wr_addr      = wr_req ? waddr_q : '0;
  assign wr_wvalid    = state == WB_DATA;
  assign wr_wdata     = wr_wvalid ? line_q[{cnt, 5'd0} +: 32] : '0;
  assign wr_wlast     = wr_wvalid && cnt == CNT_W'(LINE_WORDS - 1);
  // beats go straight into the data RAM in the cycle they arrive
  assign refill_we    = state == RD_DATA && rd_data_ok;
  assign refill_way   = lru_q;
  assign refill_idx   = cnt;
  assign refill_wdata = refill_we ? rd_data : '0;
  assign refresh      = state == REFRESH;
`ifdef CACHE_REFILL_PERF_EN
  logic [31:0] miss_cnt, wb_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (start) miss_cnt <= miss_cnt + 1'b1;
      if (start && write_back) wb_cnt <= wb_cnt + 1'b1;
    end
  end
  assign perf_miss_cnt = miss_cnt;
  assign perf_wb_cnt   = wb_cnt;
`else
  assign perf_miss_cnt = '0;
  assign perf_wb_cnt   = '0;
`endif
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed checks of clean/dirty refills, bus stalls, latched way/address, async reset and perf counters
module tb_cache_refill_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic miss, write_back, lru;
  logic [31:0] axi_raddr, axi_waddr;
  logic [511:0] victim_line;
  logic rd_req, rd_addr_ok, rd_data_ok, rd_last;
  logic [31:0] rd_addr, rd_data;
  logic wr_req, wr_addr_ok, wr_wvalid, wr_wlast, wr_data_ok, wr_done;
  logic [31:0] wr_addr, wr_wdata;
  logic refill_we, refill_way, refresh, busy;
  logic [3:0] refill_idx;
  logic [31:0] refill_wdata, perf_miss_cnt, perf_wb_cnt;
  int passed = 0, total = 0;
  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss(miss), .write_back(write_back),
    .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .lru(lru), .victim_line(victim_line),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_addr_ok(rd_addr_ok), .rd_data_ok(rd_data_ok),
    .rd_data(rd_data), .rd_last(rd_last), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_addr_ok(wr_addr_ok), .wr_wvalid(wr_wvalid), .wr_wdata(wr_wdata), .wr_wlast(wr_wlast),
    .wr_data_ok(wr_data_ok), .wr_done(wr_done), .refill_we(refill_we), .refill_way(refill_way),
    .refill_idx(refill_idx), .refill_wdata(refill_wdata), .refresh(refresh), .busy(busy),
    .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic start_miss(input logic [31:0] ra, input logic [31:0] wa, input logic wb, input logic way, input logic hold);
    axi_raddr = ra; axi_waddr = wa; write_back = wb; lru = way; miss = 1'b1;
    #1 check("idle_busy", busy, 0);
    tick;
    miss = hold;
    #1 check("start_busy", busy, 1);
  endtask
  task automatic writeback(input logic [31:0] wa, input int smax, input int dly);
    int st;
    st = $urandom_range(smax, 0);
    for (int k = 0; k < st; k++) begin
      check("wr_req_hold", wr_req, 1);
      tick;
      #1;
    end
    check("wr_req", wr_req, 1);
    check("wr_addr", wr_addr, wa);
    check("rd_req_in_wb", rd_req, 0);
    wr_addr_ok = 1'b1;
    tick;
    wr_addr_ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      st = $urandom_range(smax, 0);
      for (int k = 0; k < st; k++) begin
        wr_data_ok = 1'b0;
        #1 check("wvalid_hold", wr_wvalid, 1);
        check("wdata_hold", wr_wdata, 32'hA000_0000 + i);
        tick;
      end
      wr_data_ok = 1'b1;
      #1 check("wvalid", wr_wvalid, 1);
      check("wdata", wr_wdata, 32'hA000_0000 + i);
      check("wlast", wr_wlast, i == 15);
      tick;
    end
    wr_data_ok = 1'b0;
    for (int k = 0; k < dly; k++) begin
      #1 check("wresp_rd_req", rd_req, 0);
      check("wresp_wvalid", wr_wvalid, 0);
      tick;
    end
    wr_done = 1'b1;
    #1 check("done_rd_req", rd_req, 0);
    tick;
    wr_done = 1'b0;
    #1;
  endtask
  task automatic refill(input logic [31:0] ra, input logic way, input int smax);
    int st;
    logic [31:0] d;
    st = $urandom_range(smax, 0);
    for (int k = 0; k < st; k++) begin
      check("rd_req_hold", rd_req, 1);
      tick;
      #1;
    end
    check("rd_req", rd_req, 1);
    check("rd_addr", rd_addr, ra);
    check("wr_req_in_rd", wr_req, 0);
    rd_addr_ok = 1'b1;
    tick;
    rd_addr_ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      st = $urandom_range(smax, 0);
      for (int k = 0; k < st; k++) begin
        rd_data_ok = 1'b0;
        #1 check("we_stall", refill_we, 0);
        tick;
      end
      if (i == 8) begin
        axi_raddr = 32'hFFFF_FFC0;
        lru = ~way;
      end
      d = ra ^ 32'h5A00_0000 ^ i;
      rd_data_ok = 1'b1; rd_data = d; rd_last = i == 15;
      #1 check("refill_we", refill_we, 1);
      check("refill_idx", refill_idx, i);
      check("refill_wdata", refill_wdata, d);
      check("refill_way", refill_way, way);
      check("wr_req_beat", wr_req, 0);
      check("refresh_early", refresh, 0);
      tick;
    end
    rd_data_ok = 1'b0; rd_last = 1'b0; miss = 1'b0;
    #1 check("refresh", refresh, 1);
    check("refresh_we", refill_we, 0);
    tick;
    #1 check("refresh_once", refresh, 0);
    check("done_busy", busy, 0);
  endtask
  initial begin
    miss = 0; write_back = 0; lru = 0; axi_raddr = 0; axi_waddr = 0;
    rd_addr_ok = 0; rd_data_ok = 0; rd_data = 0; rd_last = 0;
    wr_addr_ok = 0; wr_data_ok = 0; wr_done = 0;
    for (int i = 0; i < 16; i++) victim_line[32*i +: 32] = 32'hA000_0000 + i;
    #1 check("rst_busy", busy, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_refresh", refresh, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wdata", wr_wdata, 0);
    check("rst_perf_miss", perf_miss_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    start_miss(32'h0000_1040, 32'h0, 1'b0, 1'b0, 1'b0);
    refill(32'h0000_1040, 1'b0, 0);
    start_miss(32'h0000_3080, 32'h0000_2000, 1'b1, 1'b0, 1'b0);
    writeback(32'h0000_2000, 0, 0);
    refill(32'h0000_3080, 1'b0, 0);
    start_miss(32'h0000_5100, 32'h0, 1'b0, 1'b1, 1'b0);
    refill(32'h0000_5100, 1'b1, 5);
`ifdef CACHE_REFILL_PERF_EN
    check("perf_miss", perf_miss_cnt, 3);
    check("perf_wb", perf_wb_cnt, 1);
`else
    check("perf_miss_off", perf_miss_cnt, 0);
    check("perf_wb_off", perf_wb_cnt, 0);
`endif
    start_miss(32'h0000_7000, 32'h0000_6000, 1'b1, 1'b0, 1'b0);
    writeback(32'h0000_6000, 5, 3);
    refill(32'h0000_7000, 1'b0, 5);
    start_miss(32'h0000_9040, 32'h0, 1'b0, 1'b1, 1'b1);
    refill(32'h0000_9040, 1'b1, 0);
    start_miss(32'h0000_B000, 32'h0, 1'b0, 1'b1, 1'b0);
    rd_addr_ok = 1'b1;
    tick;
    rd_addr_ok = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd_data_ok = 1'b1; rd_data = i;
      tick;
    end
    rd_data_ok = 1'b1; rd_data = 32'h1234_5678;
    #1 check("pre_rst_idx", refill_idx, 7);
    #2 rst = 1'b0;
    #1 check("arst_busy", busy, 0);
    check("arst_we", refill_we, 0);
    check("arst_idx", refill_idx, 0);
    check("arst_wdata", refill_wdata, 0);
    check("arst_way", refill_way, 0);
    check("arst_rd_req", rd_req, 0);
    check("arst_perf", perf_miss_cnt, 0);
    @(negedge clk);
    rd_data_ok = 1'b0;
    rst = 1'b1;
    start_miss(32'h0000_C000, 32'h0, 1'b0, 1'b0, 1'b0);
    refill(32'h0000_C000, 1'b0, 0);
`ifdef CACHE_REFILL_PERF_EN
    check("perf_miss_after_rst", perf_miss_cnt, 1);
    check("perf_wb_after_rst", perf_wb_cnt, 0);
`else
    check("perf_miss_off_end", perf_miss_cnt, 0);
    check("perf_wb_off_end", perf_wb_cnt, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
